// File: rtl/mips_pkg.sv
// Shared constants and encodings for the MIPS32 fetch stage.
package mips_pkg;

   localparam int unsigned ADDR_W    = 12;
   localparam int unsigned DATA_W    = 32;
   localparam logic [11:0] RESET_PC  = 12'h000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      StRun  = 1'b0,
      StHalt = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      PcHold = 2'd0,
      PcInc  = 2'd1,
      PcLoad = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC mux, +4 adder and redirect alignment check.
module pc_reg
   import mips_pkg::*;
#(
   parameter int unsigned   AW      = mips_pkg::ADDR_W,
   parameter logic [AW-1:0] RESET_V = mips_pkg::RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    pc_sel_i,
   input  logic [AW-1:0] target_i,
   output logic [AW-1:0] pc_o,
   output logic [AW-1:0] pc_plus4_o,
   output logic          target_aligned_o
);

   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pc_plus4;

   // Wraps modulo 2^AW by construction.
   assign pc_plus4         = pc_q + AW'(4);
   assign target_aligned_o = (target_i[1:0] == 2'b00);
   assign pc_o             = pc_q;
   assign pc_plus4_o       = pc_plus4;

   always_comb begin
      pc_d = pc_q;
      unique case (pc_sel_e'(pc_sel_i))
         PcInc:   pc_d = pc_plus4;
         PcLoad:  pc_d = target_i;
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_V;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, drives instruction memory and fills IF/ID.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W    = mips_pkg::ADDR_W,
   parameter int unsigned       DATA_W    = mips_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
   parameter logic [DATA_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt_req,
   input  logic              resume,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_wr,
   output logic [DATA_W-1:0] imem_wdata,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_id_valid,
   output logic [DATA_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [ADDR_W-1:0] if_id_pc4,
   output logic              halted,
   output logic              misalign_err
);

   fetch_state_e      state_q, state_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ifpc_q, ifpc_d;
   logic [ADDR_W-1:0] ifpc4_q, ifpc4_d;
   logic              err_q, err_d;

   logic [1:0]        pc_sel;
   logic [ADDR_W-1:0] pc, pc_plus4;
   logic              target_aligned;

   pc_reg #(
      .AW      (ADDR_W),
      .RESET_V (RESET_PC)
   ) u_pc_reg (
      .clk              (clk),
      .rst              (rst),
      .pc_sel_i         (pc_sel),
      .target_i         (redirect_pc),
      .pc_o             (pc),
      .pc_plus4_o       (pc_plus4),
      .target_aligned_o (target_aligned)
   );

   assign imem_addr  = pc;
   assign imem_wr    = 1'b0;
   assign imem_wdata = '0;

   always_comb begin
      state_d = state_q;
      pc_sel  = PcHold;
      valid_d = valid_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifpc4_d = ifpc4_q;
      err_d   = err_q;

      unique case (state_q)
         StRun: begin
            if (redirect) begin
               // Wrong-path word is dropped even when decode is stalled.
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               if (target_aligned) begin
                  pc_sel = PcLoad;
               end else begin
                  err_d   = 1'b1;
                  state_d = StHalt;
               end
            end else if (halt_req) begin
               state_d = StHalt;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end else if (!stall) begin
               pc_sel  = PcInc;
               valid_d = 1'b1;
               instr_d = imem_rdata;
               ifpc_d  = pc;
               ifpc4_d = pc_plus4;
            end
         end
         StHalt: begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (redirect) begin
               if (target_aligned) begin
                  pc_sel = PcLoad;
               end else begin
                  err_d = 1'b1;
               end
            end else if (resume && !err_q) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         ifpc_q  <= '0;
         ifpc4_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifpc4_q <= ifpc4_d;
         err_q   <= err_d;
      end
   end

   assign if_id_valid  = valid_q;
   assign if_id_instr  = instr_q;
   assign if_id_pc     = ifpc_q;
   assign if_id_pc4    = ifpc4_q;
   assign halted       = (state_q == StHalt);
   assign misalign_err = err_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS32 pipeline; sits directly upstream of the 4 KB byte-addressed instruction memory and feeds the IF/ID register to decode.
- Owns the PC and drives the memory address; the memory returns a 32-bit big-endian word combinationally.
- Latches word, PC and PC+4 into the IF/ID register.
- Handles stall, branch/jump redirect, halt/resume, and misaligned-target detection.

Parameters:
- ADDR_W, 12, byte-address width (4096-byte instruction space)
- DATA_W, 32, instruction width
- RESET_PC, 12'h000, PC value after reset
- NOP_INSTR, 32'h00000000, word presented in if_id_instr when the slot is a bubble (MIPS sll $0,$0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall from decode; hold PC and IF/ID
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  ADDR_W  redirect target byte address
- halt_req  in  1  request to stop fetching
- resume  in  1  leave HALT; restart at current PC
- imem_addr  out  ADDR_W  byte address to instruction memory (= PC)
- imem_wr  out  1  memory write enable; tied 0 (read-only use)
- imem_wdata  out  DATA_W  tied 0
- imem_rdata  in  DATA_W  combinational read data {mem[a],mem[a+1],mem[a+2],mem[a+3]}
- if_id_valid  out  1  IF/ID slot holds a real instruction
- if_id_instr  out  DATA_W  fetched instruction (NOP_INSTR when invalid)
- if_id_pc  out  ADDR_W  address of if_id_instr
- if_id_pc4  out  ADDR_W  if_id_pc + 4, modulo 2^ADDR_W
- halted  out  1  FSM in HALT
- misalign_err  out  1  sticky: redirect target had bits[1:0] != 0

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, state=RUN, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, halted=0, misalign_err=0.
- imem_addr = pc combinationally; imem_wr=0 and imem_wdata=0 always.
- Latency: the word at pc appears in IF/ID one posedge after pc is presented. Throughput is 1 instruction per cycle in RUN with no stall.
- States are RUN and HALT; `halted` = (state==HALT).
- RUN priority per cycle (highest first): rst > redirect > halt_req > stall > advance.
  - redirect, target aligned: pc<=redirect_pc; IF/ID becomes a bubble (valid=0, instr=NOP_INSTR). The wrong-path word is dropped. Applies even when stall=1.
  - redirect, target[1:0] != 0: misalign_err<=1; state<=HALT; pc unchanged; IF/ID bubble.
  - halt_req: state<=HALT; IF/ID bubble; pc unchanged. The instruction at pc is not consumed and is refetched on resume.
  - stall: pc, if_id_* all hold their values.
  - advance: if_id_instr<=imem_rdata; if_id_pc<=pc; if_id_pc4<=pc+4; if_id_valid<=1; pc<=pc+4.
- HALT:
  - pc held; IF/ID bubble every cycle.
  - resume=1 and misalign_err=0 -> RUN next cycle; fetch restarts at pc.
  - resume is ignored while misalign_err=1; only rst clears it.
  - redirect in HALT with an aligned target updates pc but stays in HALT.
- Wrap: pc+4 is computed modulo 4096, so 12'hFFC advances to 12'h000 with no flag. Aligned pc guarantees pc+3 <= 12'hFFF.
- rst asserted mid-stream has priority over every other input; a pending stall or redirect is discarded.

Decomposition:
- Shared package `mips_pkg` holds ADDR_W, DATA_W, NOP_INSTR, RESET_PC and the fetch state encoding (RUN=1'b0, HALT=1'b1).
- One natural sub-module: `pc_reg` (PC register plus next-PC mux and +4 adder, with aligned-check output). The IF/ID register and FSM stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, memory preloaded with words W0..W3 at 0x000..0x00C -> IF/ID shows (W0,0x000,0x004), (W1,0x004,0x008), (W2,0x008,0x00C), (W3,0x00C,0x010) with valid=1 from the 2nd posedge.
- Stall for 2 cycles while IF/ID holds W1 -> imem_addr stays 0x008 and IF/ID stays (W1,0x004) for both cycles. After release, W2 at 0x008 arrives.
- Redirect to 0x100 with stall=1 at the same time -> next cycle valid=0 and instr=0x00000000. The following cycle IF/ID = (mem word @0x100, 0x100, 0x104).
- Redirect to 0x102 -> misalign_err=1 and halted=1; resume pulses produce no fetch. After rst, misalign_err=0 and pc=0x000.
- halt_req at pc=0x020 for 1 cycle, then resume 3 cycles later -> valid=0 throughout HALT. The first instruction after resume is the word at 0x020 (not skipped).
- Redirect to 0xFFC, then advance -> IF/ID shows pc 0xFFC with pc4 0x000, and the next fetch is from 0x000.
